// File: rtl/bumpy_pkg.sv
// rtl/bumpy_pkg.sv - tile codes and game-flow state encoding shared with the map controller
package bumpy_pkg;

    localparam logic [2:0] TILE_FREE  = 3'd0;
    localparam logic [2:0] TILE_REGU  = 3'd1;
    localparam logic [2:0] TILE_GATE  = 3'd2;
    localparam logic [2:0] TILE_COIN  = 3'd3;
    localparam logic [2:0] TILE_TPORT = 3'd4;
    localparam logic [2:0] TILE_SPIKE = 3'd5;
    localparam logic [2:0] TILE_BRAKE = 3'd6;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_GATE_OPEN = 3'd2,
        ST_LVL_DONE  = 3'd3,
        ST_DEAD      = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_WIN       = 3'd6
    } game_state_t;

endpackage

// File: rtl/level_sequencer_if.sv
// rtl/level_sequencer_if.sv - physics/map-controller side signals of the level sequencer
interface level_sequencer_if;

    logic       startOfFrame;
    logic       start_key;
    logic       landed;
    logic [2:0] landed_tile;
    logic [2:0] lvl;
    logic       next_lvl;
    logic       gate;
    logic       respawn;
    logic       coin_collect;
    logic [2:0] coins;
    logic [2:0] lives;
    logic [2:0] game_state;

    modport master (
        output startOfFrame, start_key, landed, landed_tile,
        input  lvl, next_lvl, gate, respawn, coin_collect, coins, lives, game_state
    );

    modport slave (
        input  startOfFrame, start_key, landed, landed_tile,
        output lvl, next_lvl, gate, respawn, coin_collect, coins, lives, game_state
    );

endinterface

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - 8-bit frame counter, load then count down on each tick
module frame_countdown
    import bumpy_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // done fires in the cycle of the tick that takes the count from 1 to 0;
    // a load in the same cycle restarts the count and suppresses it
    always_comb begin
        cnt_d = cnt_q;
        done  = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            done  = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - Bumpy game-flow FSM: coins, gate, level advance, death and respawn
module level_sequencer
    import bumpy_pkg::*;
#(
    parameter int NUM_LEVELS     = 2,
    parameter int COINS_PER_LVL  = 2,
    parameter int START_LIVES    = 3,
    parameter int TRANS_FRAMES   = 60,
    parameter int RESPAWN_FRAMES = 90
) (
    input  logic               clk,
    input  logic               resetN,
    level_sequencer_if.slave   bus
);

    game_state_t      state_q, state_d;
    logic [2:0]       lvl_q, lvl_d;
    logic [2:0]       coins_q, coins_d;
    logic [2:0]       lives_q, lives_d;
    logic             gate_q, gate_d;
    logic             next_lvl_q, next_lvl_d;
    logic             respawn_q, respawn_d;
    logic             coin_q, coin_d;
    logic             die;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    frame_countdown u_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .tick     (bus.startOfFrame),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        coins_d    = coins_q;
        lives_d    = lives_q;
        gate_d     = gate_q;
        next_lvl_d = 1'b0;
        respawn_d  = 1'b0;
        coin_d     = 1'b0;
        die        = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = CNT_W'(TRANS_FRAMES);

        case (state_q)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (bus.start_key) begin
                    state_d    = ST_PLAY;
                    lvl_d      = '0;
                    coins_d    = '0;
                    lives_d    = 3'(START_LIVES);
                    gate_d     = 1'b0;
                    next_lvl_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.landed) begin
                    case (bus.landed_tile)
                        TILE_COIN: begin
                            coins_d = coins_q + 3'd1;
                            coin_d  = 1'b1;
                            if (coins_q + 3'd1 == 3'(COINS_PER_LVL)) begin
                                gate_d  = 1'b1;
                                state_d = ST_GATE_OPEN;
                            end
                        end
                        TILE_SPIKE: die = 1'b1;
                        TILE_FREE, TILE_REGU, TILE_GATE, TILE_TPORT, TILE_BRAKE: ;
                        default: ;
                    endcase
                end
            end
            ST_GATE_OPEN: begin
                if (bus.landed) begin
                    if (bus.landed_tile == TILE_GATE) begin
                        state_d  = ST_LVL_DONE;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(TRANS_FRAMES);
                    end else if (bus.landed_tile == TILE_SPIKE) begin
                        die = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (cnt_done) begin
                    respawn_d = 1'b1;
                    state_d   = gate_q ? ST_GATE_OPEN : ST_PLAY;
                end
            end
            ST_LVL_DONE: begin
                if (cnt_done) begin
                    if (lvl_q == 3'(NUM_LEVELS - 1)) begin
                        state_d = ST_WIN;
                    end else begin
                        lvl_d      = lvl_q + 3'd1;
                        coins_d    = '0;
                        gate_d     = 1'b0;
                        next_lvl_d = 1'b1;
                        respawn_d  = 1'b1;
                        state_d    = ST_PLAY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // coins and gate survive a death; only lives and state change
        if (die) begin
            if (lives_q > 3'd1) begin
                lives_d  = lives_q - 3'd1;
                state_d  = ST_DEAD;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(RESPAWN_FRAMES);
            end else begin
                lives_d = '0;
                state_d = ST_GAME_OVER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            lvl_q      <= '0;
            coins_q    <= '0;
            lives_q    <= 3'(START_LIVES);
            gate_q     <= 1'b0;
            next_lvl_q <= 1'b0;
            respawn_q  <= 1'b0;
            coin_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            coins_q    <= coins_d;
            lives_q    <= lives_d;
            gate_q     <= gate_d;
            next_lvl_q <= next_lvl_d;
            respawn_q  <= respawn_d;
            coin_q     <= coin_d;
        end
    end

    assign bus.lvl          = lvl_q;
    assign bus.coins        = coins_q;
    assign bus.lives        = lives_q;
    assign bus.gate         = gate_q;
    assign bus.next_lvl     = next_lvl_q;
    assign bus.respawn      = respawn_q;
    assign bus.coin_collect = coin_q;
    assign bus.game_state   = state_q;

endmodule
